axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per handshake; legal range 1..65535.
REQ-004 SHALL have ports: ACLK  in  1  clock; all logic on rising edge.
REQ-005 ARSTn  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1  command handshake.
REQ-007 cmd_write  in  1 (1=write, 0=read); cmd_addr  in  ADDR_W; cmd_data  in  DATA_W; cmd_strb  in  DATA_W/8; cmd_prot  in  3.
REQ-008 rsp_valid  out  1 / rsp_ready  in  1  response handshake; rsp_data  out  DATA_W; rsp_resp  out  2; rsp_timeout  out  1.
REQ-009 awvalid out 1, awready in 1, awaddr out ADDR_W, awprot out 3.
REQ-010 wvalid out 1, wready in 1, wdata out DATA_W, wstrb out DATA_W/8.
REQ-011 bvalid in 1, bready out 1, bresp in 2.
REQ-012 arvalid out 1, arready in 1, araddr out ADDR_W, arprot out 3.
REQ-013 rvalid in 1, rready out 1, rdata in DATA_W, rresp in 2.

Function
REQ-014 SHALL implement FSM states IDLE, AW, W, B, AR, R, RSP; one transaction outstanding at a time.
REQ-015 cmd_ready SHALL be 1 only in IDLE; command accepted when cmd_valid&&cmd_ready at rising edge; cmd_* registered on acceptance.
REQ-016 Accepted write: IDLE->AW; accepted read: IDLE->AR.
REQ-017 AW: awvalid=1 with registered addr/prot; on awvalid&&awready -> W next cycle.
REQ-018 W: wvalid=1 with registered data/strb; on wready -> B.
REQ-019 B: bready=1; on bvalid -> RSP; rsp_resp=bresp, rsp_data=0.
REQ-020 AR: arvalid=1; on arready -> R.
REQ-021 R: rready=1; on rvalid -> RSP; rsp_data=rdata, rsp_resp=rresp.
REQ-022 Valid/ready outputs SHALL be registered; each asserted starting the cycle after entering its state and deasserted the cycle after handshake (single-beat).
REQ-023 Address/data/strb outputs SHALL stay stable while the corresponding valid is high.
REQ-024 RSP: rsp_valid=1, rsp_* held stable until rsp_ready; then -> IDLE; back-to-back command accepted next cycle.
REQ-025 Wait counter 16-bit SHALL clear on each state entry, increment each cycle in AW/W/B/AR/R without handshake.
REQ-026 Counter reaching TIMEOUT SHALL drop the active valid/ready, go to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_data=0.
REQ-027 Handshake in the same cycle counter reaches TIMEOUT SHALL win; no timeout flagged.
REQ-028 cmd_valid while not in IDLE SHALL be ignored (not accepted, not lost by the requester).

Reset
REQ-029 ARSTn=0 SHALL force IDLE immediately, asynchronously, including mid-transaction.
REQ-030 Reset values: cmd_ready=0 during reset, 1 first cycle after release; all valid/ready outputs, rsp_*, addresses, data, strb, prot, counter = 0.

Verification
REQ-031 Write addr 0x0 data 0x0000_AAAA strb 0xF prot 0x7, slave ready immediately -> awvalid 1 cycle, then wvalid 1 cycle, then bready; rsp_valid with rsp_resp=0, rsp_timeout=0.
REQ-032 Writes r0=0x0000_AAAA, r1=0xBBBB_0000, ctrl(0x3)=0x3, then read addr 0x2 -> rsp_data=0xBBBB_AAAA, rsp_resp=0.
REQ-033 awready held low 5 cycles -> awvalid held 6 cycles, awaddr stable throughout, transaction completes normally.
REQ-034 TIMEOUT=4, arready never asserted -> arvalid drops after 4 wait cycles; rsp_timeout=1, rsp_resp=2'b10; next command accepted.
REQ-035 rsp_ready held low 3 cycles -> rsp_valid/rsp_data stable 3+ cycles, cmd_ready stays 0 until rsp_ready.
REQ-036 ARSTn pulsed low while in W with wvalid=1 -> wvalid=0 at once; after release cmd_ready=1 and a fresh write completes.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite single-outstanding master: one command in, one AXI transaction out,
// one response back. Every handshake stage is guarded by a wait-cycle timeout.
module axi4_lite_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                ACLK,
  input  logic                ARSTn,
  // command
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  // response
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  // write address
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  // write data
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  // write response
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  // read address
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  // read data
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AW   = 3'd1;
  localparam logic [2:0] W    = 3'd2;
  localparam logic [2:0] B    = 3'd3;
  localparam logic [2:0] AR   = 3'd4;
  localparam logic [2:0] R    = 3'd5;
  localparam logic [2:0] RSP  = 3'd6;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [2:0]          state_q, state_d;
  logic [15:0]         cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [2:0]          prot_q;
  logic                cmd_ready_q;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                accept, hs, waiting, expired;

  assign accept  = cmd_valid & cmd_ready_q;
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    hs      = 1'b0;
    waiting = 1'b1;
    case (state_q)
      AW:      hs = awvalid_q & awready;
      W:       hs = wvalid_q & wready;
      B:       hs = bready_q & bvalid;
      AR:      hs = arvalid_q & arready;
      R:       hs = rready_q & rvalid;
      default: waiting = 1'b0;
    endcase
  end

  // A handshake in the expiring cycle takes priority over the timeout.
  assign expired = waiting & ~hs & (cnt_inc == TIMEOUT_C);

  always_comb begin
    state_d       = state_q;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: if (accept) state_d = cmd_write ? AW : AR;
      AW:   if (hs) state_d = W;
      W:    if (hs) state_d = B;
      B: begin
        if (hs) begin
          state_d       = RSP;
          rsp_data_d    = '0;
          rsp_resp_d    = bresp;
          rsp_timeout_d = 1'b0;
        end
      end
      AR:   if (hs) state_d = R;
      R: begin
        if (hs) begin
          state_d       = RSP;
          rsp_data_d    = rdata;
          rsp_resp_d    = rresp;
          rsp_timeout_d = 1'b0;
        end
      end
      RSP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expired) begin
      state_d       = RSP;
      rsp_data_d    = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_inc;
  end

  // Valid/ready outputs are registered decodes of the next state, so each one
  // rises on the edge entering its state and falls on the edge that leaves it.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      prot_q        <= '0;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      if (accept) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        strb_q <= cmd_strb;
        prot_q <= cmd_prot;
      end
      cmd_ready_q   <= (state_d == IDLE);
      awvalid_q     <= (state_d == AW);
      wvalid_q      <= (state_d == W);
      bready_q      <= (state_d == B);
      arvalid_q     <= (state_d == AR);
      rready_q      <= (state_d == R);
      rsp_valid_q   <= (state_d == RSP);
      rsp_data_q    <= rsp_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign awvalid     = awvalid_q;
  assign awaddr      = addr_q;
  assign awprot      = prot_q;
  assign wvalid      = wvalid_q;
  assign wdata       = data_q;
  assign wstrb       = strb_q;
  assign bready      = bready_q;
  assign arvalid     = arvalid_q;
  assign araddr      = addr_q;
  assign arprot      = prot_q;
  assign rready      = rready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: register-file slave model with per-channel stall
// knobs, scoreboard of expected responses, plus a TIMEOUT=4 instance with a dead slave.
module tb_axi4_lite_master;

  logic        ACLK;
  logic        ARSTn;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  logic        t_cmd_valid, t_cmd_ready, t_cmd_write;
  logic [31:0] t_cmd_addr, t_cmd_data;
  logic [3:0]  t_cmd_strb;
  logic [2:0]  t_cmd_prot;
  logic        t_rsp_valid, t_rsp_ready, t_rsp_timeout;
  logic [31:0] t_rsp_data;
  logic [1:0]  t_rsp_resp;
  logic        t_awvalid, t_awready, t_wvalid, t_wready, t_bvalid, t_bready;
  logic        t_arvalid, t_arready, t_rvalid, t_rready;
  logic [31:0] t_awaddr, t_araddr, t_wdata, t_rdata;
  logic [2:0]  t_awprot, t_arprot;
  logic [3:0]  t_wstrb;
  logic [1:0]  t_bresp, t_rresp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        to;
  } exp_t;
  exp_t sb_q[$];

  // slave model state
  logic [31:0] slv_regs [4];
  logic [31:0] slv_awaddr;
  logic [1:0]  slv_bresp, slv_rresp;
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          pend_b, pend_r;

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_to (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_write(t_cmd_write),
    .cmd_addr(t_cmd_addr), .cmd_data(t_cmd_data), .cmd_strb(t_cmd_strb),
    .cmd_prot(t_cmd_prot),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
    .rsp_resp(t_rsp_resp), .rsp_timeout(t_rsp_timeout),
    .awvalid(t_awvalid), .awready(t_awready), .awaddr(t_awaddr), .awprot(t_awprot),
    .wvalid(t_wvalid), .wready(t_wready), .wdata(t_wdata), .wstrb(t_wstrb),
    .bvalid(t_bvalid), .bready(t_bready), .bresp(t_bresp),
    .arvalid(t_arvalid), .arready(t_arready), .araddr(t_araddr), .arprot(t_arprot),
    .rvalid(t_rvalid), .rready(t_rready), .rdata(t_rdata), .rresp(t_rresp)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] slv_read(input logic [1:0] idx);
    // Address 2 is a combined view of r0|r1, enabled when ctrl[1:0] == 3.
    if (idx == 2'd2) return (slv_regs[3][1:0] == 2'b11) ? (slv_regs[0] | slv_regs[1]) : 32'h0;
    return slv_regs[idx];
  endfunction

  // Slave: ready/valid driven on the falling edge, held low for *_dly cycles.
  always @(negedge ACLK) begin
    if (!ARSTn) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
      else begin wready = 0; w_cnt = 0; end
      if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin arready = 0; ar_cnt = 0; end
      if (pend_b) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
      else begin bvalid = 0; b_cnt = 0; end
      if (pend_r) begin rvalid = (r_cnt >= r_dly); r_cnt++; end
      else begin rvalid = 0; r_cnt = 0; end
    end
  end

  always @(posedge ACLK) begin
    if (!ARSTn) begin
      pend_b = 0;
      pend_r = 0;
    end else begin
      if (awvalid && awready) slv_awaddr = awaddr;
      if (wvalid && wready) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) slv_regs[slv_awaddr[1:0]][8*b +: 8] = wdata[8*b +: 8];
        pend_b = 1;
      end
      if (bvalid && bready) pend_b = 0;
      if (arvalid && arready) begin
        rdata  = slv_read(araddr[1:0]);
        pend_r = 1;
      end
      if (rvalid && rready) pend_r = 0;
    end
  end

  assign bresp = slv_bresp;
  assign rresp = slv_rresp;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic [31:0] edata, input logic [1:0] eresp, input logic eto);
    exp_t e;
    int   n = 0;
    cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_strb = strb; cmd_prot = prot;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    e.data = edata; e.resp = eresp; e.to = eto;
    sb_q.push_back(e);
  endtask

  task automatic wait_rsp(input int hold, input string name);
    exp_t        e;
    int          n = 0;
    logic [31:0] d0;
    logic [1:0]  r0;
    logic        t0;
    bit          bad = 0;
    while (rsp_valid !== 1'b1 && n < 600) begin tick(); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_wait: rsp_valid=%b after %0d cycles, want 1", name, rsp_valid, n);
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s sb_empty: got response data=%h with no expectation", name, rsp_data);
      return;
    end
    e  = sb_q.pop_front();
    d0 = rsp_data; r0 = rsp_resp; t0 = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_resp !== r0 || rsp_timeout !== t0 ||
          cmd_ready !== 1'b0) bad = 1;
    end
    if (hold > 0) begin
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s rsp_hold: valid=%b data=%h cmd_ready=%b, want 1 %h 0 held stable",
                 name, rsp_valid, rsp_data, cmd_ready, d0);
      end
    end
    checks++;
    if (rsp_data !== e.data || rsp_resp !== e.resp || rsp_timeout !== e.to) begin
      errors++;
      $display("FAIL %s rsp: data=%h resp=%b to=%b, want data=%h resp=%b to=%b",
               name, rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.to);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_done: rsp_valid=%b cmd_ready=%b, want 0 1", name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    ARSTn = 1'b0;
    #12;
    checks++;
    if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout} !== 8'h0 ||
        {rsp_data, rsp_resp, awaddr, araddr, wdata, wstrb, awprot, arprot} !== '0) begin
      errors++;
      $display("FAIL reset_values: ctl=%b rsp=%h/%b awaddr=%h wdata=%h wstrb=%h prot=%h, want all 0",
               {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout},
               rsp_data, rsp_resp, awaddr, wdata, wstrb, awprot);
    end
    ARSTn = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || t_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b t_cmd_ready=%b, want 1 1", cmd_ready, t_cmd_ready);
    end
  endtask

  task automatic test_single_write();
    send_cmd(1'b1, 32'h0, 32'h0000_AAAA, 4'hF, 3'h7, 32'h0, 2'b00, 1'b0);
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 32'h0 || awprot !== 3'h7 || wvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_aw: awvalid=%b awaddr=%h awprot=%h wvalid=%b, want 1 0 7 0",
               awvalid, awaddr, awprot, wvalid);
    end
    tick();
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b1 || wdata !== 32'h0000_AAAA || wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wr_w: awvalid=%b wvalid=%b wdata=%h wstrb=%h, want 0 1 0000aaaa f",
               awvalid, wvalid, wdata, wstrb);
    end
    tick();
    checks++;
    if (wvalid !== 1'b0 || bready !== 1'b1) begin
      errors++;
      $display("FAIL wr_b: wvalid=%b bready=%b, want 0 1", wvalid, bready);
    end
    wait_rsp(0, "single_write");
  endtask

  task automatic test_reg_readback();
    send_cmd(1'b1, 32'h0, 32'h0000_AAAA, 4'hF, 3'h0, 32'h0, 2'b00, 1'b0);
    wait_rsp(0, "wr_r0");
    send_cmd(1'b1, 32'h1, 32'hBBBB_0000, 4'hF, 3'h0, 32'h0, 2'b00, 1'b0);
    wait_rsp(0, "wr_r1");
    send_cmd(1'b1, 32'h3, 32'h0000_0003, 4'hF, 3'h0, 32'h0, 2'b00, 1'b0);
    wait_rsp(0, "wr_ctrl");
    send_cmd(1'b0, 32'h2, 32'h0, 4'h0, 3'h2, 32'hBBBB_AAAA, 2'b00, 1'b0);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h2 || arprot !== 3'h2 || awvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_ar: arvalid=%b araddr=%h arprot=%h awvalid=%b, want 1 2 2 0",
               arvalid, araddr, arprot, awvalid);
    end
    wait_rsp(0, "rd_combined");
    // Low byte only: r1 becomes BBBB_0078.
    send_cmd(1'b1, 32'h1, 32'h1234_5678, 4'b0001, 3'h0, 32'h0, 2'b00, 1'b0);
    wait_rsp(0, "wr_strb");
    send_cmd(1'b0, 32'h1, 32'h0, 4'h0, 3'h0, 32'hBBBB_0078, 2'b00, 1'b0);
    wait_rsp(0, "rd_strb");
  endtask

  task automatic test_aw_stall();
    int  n = 0;
    bit  moved = 0;
    aw_dly = 5;
    send_cmd(1'b1, 32'h0, 32'h0000_AAAA, 4'hF, 3'h1, 32'h0, 2'b00, 1'b0);
    while (awvalid === 1'b1 && n < 20) begin
      if (awaddr !== 32'h0 || awprot !== 3'h1) moved = 1;
      n++;
      tick();
    end
    checks++;
    if (n != 6 || moved) begin
      errors++;
      $display("FAIL aw_stall: awvalid cycles=%0d addr_moved=%0d, want 6 0", n, moved);
    end
    aw_dly = 0;
    wait_rsp(0, "aw_stall");
  endtask

  task automatic test_resp_backpressure();
    r_dly = 2;
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 32'h0000_AAAA, 2'b00, 1'b0);
    wait_rsp(3, "rsp_backpressure");
    r_dly = 0;
  endtask

  task automatic test_error_resp();
    slv_bresp = 2'b10;
    b_dly     = 2;
    send_cmd(1'b1, 32'h3, 32'h0000_0003, 4'hF, 3'h0, 32'h0, 2'b10, 1'b0);
    wait_rsp(0, "bresp_slverr");
    slv_bresp = 2'b00;
    b_dly     = 0;
    slv_rresp = 2'b01;
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 32'h0000_AAAA, 2'b01, 1'b0);
    wait_rsp(0, "rresp_exokay");
    slv_rresp = 2'b00;
  endtask

  task automatic test_timeout_boundary();
    aw_dly = 254;
    send_cmd(1'b1, 32'h0, 32'h0000_AAAA, 4'hF, 3'h0, 32'h0, 2'b00, 1'b0);
    wait_rsp(0, "hs_at_limit");
    aw_dly = 255;
    send_cmd(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 3'h0, 32'h0, 2'b10, 1'b1);
    wait_rsp(0, "aw_timeout");
    aw_dly = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    t_cmd_write = 1'b0; t_cmd_addr = 32'h10; t_cmd_valid = 1'b1;
    checks++;
    if (t_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_cmd_ready: t_cmd_ready=%b, want 1", t_cmd_ready);
    end
    tick();
    t_cmd_valid = 1'b0;
    while (t_arvalid === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL to_arvalid_cycles: got %0d, want 4", n);
    end
    checks++;
    if (t_rsp_valid !== 1'b1 || t_rsp_timeout !== 1'b1 || t_rsp_resp !== 2'b10 ||
        t_rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL to_rsp: valid=%b to=%b resp=%b data=%h, want 1 1 10 0",
               t_rsp_valid, t_rsp_timeout, t_rsp_resp, t_rsp_data);
    end
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;
    checks++;
    if (t_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_idle: t_cmd_ready=%b, want 1", t_cmd_ready);
    end
    t_cmd_valid = 1'b1;
    tick();
    t_cmd_valid = 1'b0;
    checks++;
    if (t_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL to_next_cmd: t_arvalid=%b, want 1", t_arvalid);
    end
    n = 0;
    while (t_rsp_valid !== 1'b1 && n < 20) begin n++; tick(); end
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send_cmd(1'b1, 32'h1, 32'hBBBB_0000, 4'hF, 3'h0, 32'h0, 2'b00, 1'b0);
    // Read is requested while the write is in flight and must wait, not vanish.
    cmd_write = 1'b0; cmd_addr = 32'h2; cmd_valid = 1'b1;
    e.data = 32'hBBBB_AAAA; e.resp = 2'b00; e.to = 1'b0;
    sb_q.push_back(e);
    tick();
    checks++;
    if (cmd_ready !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: cmd_ready=%b arvalid=%b, want 0 0", cmd_ready, arvalid);
    end
    wait_rsp(0, "b2b_write");
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h2) begin
      errors++;
      $display("FAIL b2b_accept: arvalid=%b araddr=%h, want 1 2", arvalid, araddr);
    end
    wait_rsp(0, "b2b_read");
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    w_dly = 100;
    send_cmd(1'b1, 32'h0, 32'h1111_1111, 4'hF, 3'h0, 32'h0, 2'b00, 1'b0);
    while (wvalid !== 1'b1 && n < 10) begin n++; tick(); end
    checks++;
    if (wvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_enter_w: wvalid=%b, want 1", wvalid);
    end
    tick();
    #2;
    ARSTn = 1'b0;
    #1;
    checks++;
    if (wvalid !== 1'b0 || awvalid !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: wvalid=%b awvalid=%b cmd_ready=%b rsp_valid=%b, want 0 0 0 0",
               wvalid, awvalid, cmd_ready, rsp_valid);
    end
    sb_q.delete();
    w_dly = 0;
    @(posedge ACLK);
    #3;
    ARSTn = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || wvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: cmd_ready=%b wvalid=%b, want 1 0", cmd_ready, wvalid);
    end
    send_cmd(1'b1, 32'h0, 32'h2222_2222, 4'hF, 3'h0, 32'h0, 2'b00, 1'b0);
    wait_rsp(0, "rst_fresh_write");
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 32'h2222_2222, 2'b00, 1'b0);
    wait_rsp(0, "rst_fresh_read");
  endtask

  initial begin
    ARSTn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0; cmd_strb = 0; cmd_prot = 0;
    rsp_ready = 0; rdata = 0;
    t_cmd_valid = 0; t_cmd_write = 0; t_cmd_addr = 0; t_cmd_data = 0; t_cmd_strb = 0;
    t_cmd_prot = 0; t_rsp_ready = 0;
    t_awready = 0; t_wready = 0; t_bvalid = 0; t_bresp = 0;
    t_arready = 0; t_rvalid = 0; t_rdata = 0; t_rresp = 0;
    slv_bresp = 0; slv_rresp = 0; slv_awaddr = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    for (int i = 0; i < 4; i++) slv_regs[i] = 32'h0;

    test_reset();
    test_single_write();
    test_reg_readback();
    test_aw_stall();
    test_resp_backpressure();
    test_error_resp();
    test_timeout_boundary();
    test_timeout();
    test_back_to_back();
    test_reset_mid_write();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected responses never seen, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
